usb_rcv_core: RTL and testbench

USB_RCV_CORE -- requirements
Module: usb_rcv_core

---
 rtl/usb_pkg.sv | 26 ++
 rtl/usb_bit_timer.sv | 38 +++
 rtl/usb_rcv_core.sv | 227 ++++++++++++++++++++++
 tb/tb_usb_rcv_core.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed receive path: FSM states,
// the SYNC pattern and the bit-stuffing run length.
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC     = 3'd1,
        RCV_BYTE = 3'd2,
        EOP      = 3'd3,
        EOP_WAIT = 3'd4
    } rcv_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam int         STUFF_RUN = 6;

    // Single-ended zero: both lines low.
    function automatic logic is_se0(input logic dp, input logic dm);
        return (dp == 1'b0) && (dm == 1'b0);
    endfunction

    // Full-speed J state: D+ high, D- low.
    function automatic logic is_j(input logic dp, input logic dm);
        return (dp == 1'b1) && (dm == 1'b0);
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period counter that re-aligns on line transitions and emits a
// one-clock sample strobe part way into each bit cell.
module usb_bit_timer #(
    parameter int BIT_CLKS  = 8,
    parameter int SAMPLE_PT = 3
) (
    input  logic clk,
    input  logic srst,
    input  logic enable,
    input  logic clear,
    output logic strobe
);

    localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (enable) begin
            cnt_next = (cnt_reg == CW'(BIT_CLKS - 1)) ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign strobe = enable && (cnt_reg == CW'(SAMPLE_PT));

endmodule

// File: rtl/usb_rcv_core.sv
// USB full-speed receiver: line synchronisation, NRZI decode, bit unstuffing,
// SYNC/EOP detection and byte delivery to the rx FIFO.
module usb_rcv_core
    import usb_pkg::*;
#(
    parameter int BIT_CLKS  = 8,
    parameter int SAMPLE_PT = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    input  logic       full,
    output logic       w_enable,
    output logic [7:0] w_data,
    output logic       rcving,
    output logic       r_error
);

    // Index 0 is D+ (idles high), index 1 is D- (idles low).
    logic [1:0] line_raw;
    logic [1:0] line_sync;

    assign line_raw = {d_minus, d_plus};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            localparam logic RST_VAL = (gi == 0) ? 1'b1 : 1'b0;
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (n_rst) begin
                    meta_reg <= RST_VAL;
                    sync_reg <= RST_VAL;
                end else begin
                    meta_reg <= line_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign line_sync[gi] = sync_reg;
        end
    endgenerate

    logic dp_sync;
    logic dm_sync;
    logic dp_prev_reg;
    logic dp_fall;
    logic dp_edge;

    assign dp_sync = line_sync[0];
    assign dm_sync = line_sync[1];
    assign dp_fall = dp_prev_reg & ~dp_sync;
    assign dp_edge = dp_prev_reg ^ dp_sync;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            dp_prev_reg <= 1'b1;
        end else begin
            dp_prev_reg <= dp_sync;
        end
    end

    rcv_state_t state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0] ones_cnt_reg, ones_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic       prev_bit_reg, prev_bit_next;
    logic       se0_seen_reg, se0_seen_next;
    logic       w_enable_reg, w_enable_next;
    logic [7:0] w_data_reg, w_data_next;
    logic       rcving_reg, rcving_next;
    logic       r_error_reg, r_error_next;

    logic       start_pkt;
    logic       strobe;
    logic       line_se0;
    logic       line_j;
    logic       new_bit;
    logic [7:0] byte_next;

    assign start_pkt = (state_reg == IDLE) && dp_fall;
    assign line_se0  = is_se0(dp_sync, dm_sync);
    assign line_j    = is_j(dp_sync, dm_sync);
    assign new_bit   = (dp_sync == prev_bit_reg);
    assign byte_next = {new_bit, shift_reg[7:1]};

    // Every D+ transition during a packet re-aligns the sample point.
    usb_bit_timer #(
        .BIT_CLKS  (BIT_CLKS),
        .SAMPLE_PT (SAMPLE_PT)
    ) u_bit_timer (
        .clk    (clk),
        .srst   (n_rst),
        .enable (rcving_reg),
        .clear  (start_pkt || (rcving_reg && dp_edge)),
        .strobe (strobe)
    );

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        ones_cnt_next = ones_cnt_reg;
        shift_next    = shift_reg;
        prev_bit_next = prev_bit_reg;
        se0_seen_next = se0_seen_reg;
        w_enable_next = 1'b0;
        w_data_next   = w_data_reg;
        rcving_next   = rcving_reg;
        r_error_next  = r_error_reg;

        case (state_reg)
            IDLE: begin
                if (dp_fall) begin
                    state_next    = SYNC;
                    rcving_next   = 1'b1;
                    r_error_next  = 1'b0;
                    bit_cnt_next  = 3'd0;
                    ones_cnt_next = 3'd0;
                    shift_next    = 8'h00;
                    prev_bit_next = 1'b1;
                    se0_seen_next = 1'b0;
                end
            end

            SYNC, RCV_BYTE: begin
                if (strobe) begin
                    if (line_se0) begin
                        // Only a byte-aligned SE0 after SYNC is a clean EOP.
                        state_next = EOP;
                        if ((state_reg == SYNC) || (bit_cnt_reg != 3'd0)) begin
                            r_error_next = 1'b1;
                        end
                    end else begin
                        prev_bit_next = dp_sync;
                        if (ones_cnt_reg == 3'(STUFF_RUN)) begin
                            // Stuffed bit: dropped, and must have been a zero.
                            ones_cnt_next = 3'd0;
                            if (new_bit) begin
                                r_error_next  = 1'b1;
                                state_next    = EOP_WAIT;
                                se0_seen_next = 1'b0;
                            end
                        end else begin
                            shift_next    = byte_next;
                            ones_cnt_next = new_bit ? ones_cnt_reg + 3'd1 : 3'd0;
                            bit_cnt_next  = bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                if (state_reg == SYNC) begin
                                    if (byte_next == SYNC_BYTE) begin
                                        state_next = RCV_BYTE;
                                    end else begin
                                        r_error_next  = 1'b1;
                                        state_next    = EOP_WAIT;
                                        se0_seen_next = 1'b0;
                                    end
                                end else if (!full) begin
                                    w_enable_next = 1'b1;
                                    w_data_next   = byte_next;
                                end else begin
                                    r_error_next  = 1'b1;
                                    state_next    = EOP_WAIT;
                                    se0_seen_next = 1'b0;
                                end
                            end
                        end
                    end
                end
            end

            EOP: begin
                if (strobe && line_j) begin
                    state_next  = IDLE;
                    rcving_next = 1'b0;
                end
            end

            EOP_WAIT: begin
                if (strobe) begin
                    if (line_se0) begin
                        se0_seen_next = 1'b1;
                    end else if (se0_seen_reg && line_j) begin
                        state_next  = IDLE;
                        rcving_next = 1'b0;
                    end
                end
            end

            default: begin
                state_next  = IDLE;
                rcving_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            ones_cnt_reg <= 3'd0;
            shift_reg    <= 8'h00;
            prev_bit_reg <= 1'b1;
            se0_seen_reg <= 1'b0;
            w_enable_reg <= 1'b0;
            w_data_reg   <= 8'h00;
            rcving_reg   <= 1'b0;
            r_error_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            ones_cnt_reg <= ones_cnt_next;
            shift_reg    <= shift_next;
            prev_bit_reg <= prev_bit_next;
            se0_seen_reg <= se0_seen_next;
            w_enable_reg <= w_enable_next;
            w_data_reg   <= w_data_next;
            rcving_reg   <= rcving_next;
            r_error_reg  <= r_error_next;
        end
    end

    assign w_enable = w_enable_reg;
    assign w_data   = w_data_reg;
    assign rcving   = rcving_reg;
    assign r_error  = r_error_reg;

endmodule

// File: tb/tb_usb_rcv_core.sv
// Bench for usb_rcv_core: builds USB line waveforms (stuffing + NRZI) from
// byte lists and checks the FIFO writes and status flags that should result.
module tb_usb_rcv_core;

    localparam int BIT_CLKS = 8;
    localparam int STUFF    = 6;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       d_plus = 1'b1;
    logic       d_minus = 1'b0;
    logic       full = 1'b0;
    logic       w_enable;
    logic [7:0] w_data;
    logic       rcving;
    logic       r_error;

    usb_rcv_core #(.BIT_CLKS(BIT_CLKS), .SAMPLE_PT(3)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .full     (full),
        .w_enable (w_enable),
        .w_data   (w_data),
        .rcving   (rcving),
        .r_error  (r_error)
    );

    always #5 clk = ~clk;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] tx_q[$];
    logic [1:0] line_q[$];
    logic [7:0] got_q[$];
    int         double_we = 0;
    int         rcv_cycles = 0;
    logic       we_prev = 1'b0;
    logic       probe_err;
    logic       probe_rcv;
    int         base_w;
    int         base_dbl;
    int         base_rcv;

    always @(negedge clk) begin
        if (!n_rst) begin
            if (w_enable) begin
                got_q.push_back(w_data);
                if (we_prev) double_we++;
            end
            if (rcving) rcv_cycles++;
        end
        we_prev = w_enable;
    end

    // Reference encoder: sync + bytes LSB first, a stuff bit after every six
    // ones, NRZI (0 = toggle), then SE0 SE0 J and trailing idle.
    task automatic build(input logic [7:0] sync_b, input int trunc_bits, input bit stuff_one);
        bit raw[$];
        bit lvl;
        int ones;
        raw = {};
        for (int k = 0; k < 8; k++) raw.push_back(sync_b[k]);
        for (int i = 0; i < tx_q.size(); i++) begin
            logic [7:0] b;
            int nb;
            b  = tx_q[i];
            nb = (i == tx_q.size() - 1 && trunc_bits >= 0) ? trunc_bits : 8;
            for (int k = 0; k < nb; k++) raw.push_back(b[k]);
        end
        line_q = {};
        line_q.push_back(2'b10);
        line_q.push_back(2'b10);
        lvl  = 1'b1;
        ones = 0;
        for (int i = 0; i < raw.size(); i++) begin
            if (!raw[i]) lvl = ~lvl;
            line_q.push_back({lvl, ~lvl});
            ones = raw[i] ? ones + 1 : 0;
            if (ones == STUFF) begin
                if (!stuff_one) lvl = ~lvl;
                line_q.push_back({lvl, ~lvl});
                ones = 0;
            end
        end
        line_q.push_back(2'b00);
        line_q.push_back(2'b00);
        for (int i = 0; i < 3; i++) line_q.push_back(2'b10);
    endtask

    task automatic drive_line(input int rst_at, input int probe_at);
        base_w   = got_q.size();
        base_dbl = double_we;
        base_rcv = rcv_cycles;
        for (int i = 0; i < line_q.size(); i++) begin
            for (int c = 0; c < BIT_CLKS; c++) begin
                @(posedge clk); #1;
                {d_plus, d_minus} = line_q[i];
                if (i == probe_at && c == 4) begin
                    probe_err = r_error;
                    probe_rcv = rcving;
                end
                if (i == rst_at && c == 2) begin
                    n_rst = 1'b1;
                    repeat (2) @(posedge clk);
                    #1;
                    d_plus  = 1'b1;
                    d_minus = 1'b0;
                    n_rst   = 1'b0;
                    repeat (20) @(posedge clk);
                    return;
                end
            end
        end
        d_plus  = 1'b1;
        d_minus = 1'b0;
        repeat (16) @(posedge clk);
    endtask

    task automatic test_reset;
        logic [10:0] obs;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = {w_enable, w_data, rcving, r_error};
        tests_run++;
        if (obs !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 000", obs);
        end
        @(posedge clk); #1;
        n_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs = {w_enable, w_data, rcving, r_error};
            tests_run++;
            if (obs !== 11'd0) begin
                tests_failed++;
                $display("FAIL idle_quiet[%0d]: got %h expected 000", i, obs);
            end
        end
        $display("[TB] reset: outputs checked during reset and 20 idle clocks");
    endtask

    // Checks the writes seen since drive_line started against tx-derived expectation.
    task automatic check_pkt(input string name, input int n_exp, input logic err_exp);
        int n_got;
        @(negedge clk);
        n_got = got_q.size() - base_w;
        tests_run++;
        if (n_got != n_exp) begin
            tests_failed++;
            $display("FAIL %s write_count: got %0d expected %0d", name, n_got, n_exp);
        end
        for (int i = 0; i < n_exp && i < n_got; i++) begin
            tests_run++;
            if (got_q[base_w + i] !== tx_q[i]) begin
                tests_failed++;
                $display("FAIL %s byte[%0d]: got %h expected %h", name, i, got_q[base_w + i], tx_q[i]);
            end
        end
        tests_run++;
        if (r_error !== err_exp) begin
            tests_failed++;
            $display("FAIL %s r_error: got %b expected %b", name, r_error, err_exp);
        end
        tests_run++;
        if (rcving !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s rcving_end: got %b expected 0", name, rcving);
        end
        tests_run++;
        if (double_we != base_dbl) begin
            tests_failed++;
            $display("FAIL %s double_write: got %0d expected %0d", name, double_we, base_dbl);
        end
        $display("[TB] %s: %0d writes, r_error=%b", name, n_got, r_error);
    endtask

    task automatic test_clean;
        tx_q = '{8'hA5, 8'h3C};
        build(8'h80, -1, 1'b0);
        drive_line(-1, -1);
        tests_run++;
        if (rcv_cycles == base_rcv) begin
            tests_failed++;
            $display("FAIL clean rcving_seen: got 0 cycles expected >0");
        end
        check_pkt("clean", 2, 1'b0);
    endtask

    task automatic test_stuffing;
        tx_q = '{8'hFF};
        build(8'h80, -1, 1'b0);
        drive_line(-1, -1);
        check_pkt("stuff0", 1, 1'b0);
        build(8'h80, -1, 1'b1);
        drive_line(-1, -1);
        check_pkt("stuff1", 0, 1'b1);
    endtask

    task automatic test_bad_sync;
        tx_q = '{8'h00};
        build(8'h81, -1, 1'b0);
        drive_line(-1, -1);
        check_pkt("bad_sync", 0, 1'b1);
        tx_q = '{8'h12};
        build(8'h80, -1, 1'b0);
        drive_line(-1, 6);
        tests_run++;
        if ({probe_rcv, probe_err} !== 2'b10) begin
            tests_failed++;
            $display("FAIL err_clear_at_start: got rcving/r_error %b%b expected 10", probe_rcv, probe_err);
        end
        check_pkt("after_bad", 1, 1'b0);
    endtask

    task automatic test_se0_full;
        tx_q = '{8'hA5, 8'h0F};
        build(8'h80, 4, 1'b0);
        drive_line(-1, -1);
        check_pkt("se0_partial", 1, 1'b1);
        tx_q = '{8'h55};
        build(8'h80, -1, 1'b0);
        full = 1'b1;
        drive_line(-1, -1);
        full = 1'b0;
        check_pkt("fifo_full", 0, 1'b1);
    endtask

    task automatic test_reset_mid;
        tx_q = '{8'h00};
        build(8'h80, -1, 1'b0);
        drive_line(2 + 8 + 2, -1);
        check_pkt("reset_mid", 0, 1'b0);
        tx_q = '{8'hC3, 8'h7E};
        build(8'h80, -1, 1'b0);
        drive_line(-1, -1);
        check_pkt("after_reset", 2, 1'b0);
    endtask

    task automatic test_random;
        for (int p = 0; p < 8; p++) begin
            int n;
            n = $urandom_range(1, 4);
            tx_q = {};
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            build(8'h80, -1, 1'b0);
            drive_line(-1, -1);
            check_pkt("random", n, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_stuffing();
        test_bad_sync();
        test_se0_full();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
